descrambler_8: RTL and testbench
================================

DESCRAMBLER_8 -- requirements
Module: descrambler_8

Interface
REQ-001 The block SHALL have parameter LFSR_SEED, default 16'hFFFF, as the LFSR value loaded on reset and on COM.
REQ-002 The block SHALL have parameter COM_SYM, default 8'hBC (K28.5), as the COM symbol value.
REQ-003 The block SHALL have parameter SKP_SYM, default 8'h1C (K28.0), as the SKP symbol value.
REQ-004 The block SHALL have port pclk, input, 1 bit: the only clock; all logic is on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data and in_k hold a received symbol this cycle.
REQ-007 The block SHALL have port in_data, input, 8 bits: received symbol after 8b/10b decode.
REQ-008 The block SHALL have port in_k, input, 1 bit: 1 means in_data is a K character.
REQ-009 The block SHALL have port descr_bypass, input, 1 bit: 1 means the LTSSM has disabled scrambling and data passes through unmodified.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data and out_k hold a processed symbol.
REQ-011 The block SHALL have port out_data, output, 8 bits: descrambled symbol.
REQ-012 The block SHALL have port out_k, output, 1 bit: registered copy of in_k.
REQ-013 The block SHALL have port locked, output, 1 bit: 1 once a COM has been received since reset.

Function
REQ-014 The LFSR SHALL implement the PCIe Gen1/2 polynomial x^16+x^5+x^4+x^3+1 and advance 8 bit-steps per advancing symbol, using the same next-state equations and key mapping as the TX scrambler, with key[7:0] = lfsr[8..15] bit-reversed.
REQ-015 Output latency SHALL be exactly 1 cycle: out_valid(t+1) = in_valid(t), and out_data and out_k are registered.
REQ-016 When in_valid=0, the LFSR, out_data, out_k and locked SHALL hold their values, and out_valid SHALL be 0 on the next cycle.
REQ-017 When a symbol is COM (in_k=1, in_data=COM_SYM), the next LFSR value SHALL be LFSR_SEED, locked SHALL become 1, and out_data SHALL be in_data.
REQ-018 When a symbol is SKP (in_k=1, in_data=SKP_SYM), the LFSR SHALL hold and out_data SHALL be in_data.
REQ-019 Any other K symbol SHALL advance the LFSR and pass out_data = in_data.
REQ-020 A D symbol SHALL produce out_data = in_data XOR key and advance the LFSR.
REQ-021 When descr_bypass=1, D symbols SHALL pass unmodified, while LFSR advance, hold and COM reload SHALL still follow REQ-017 to REQ-019.
REQ-022 Before lock (locked=0), D symbols SHALL still be XORed with the current key, and downstream logic SHALL ignore the data until locked=1.
REQ-023 Back-to-back COM symbols SHALL each reload LFSR_SEED, so the first D symbol after the final COM uses key 8'hFF.
REQ-024 The block SHALL be a two-state machine, UNLOCKED to LOCKED on the first valid COM, with no exit except reset.

Reset
REQ-025 While reset=1 on a pclk edge, the LFSR SHALL load LFSR_SEED and out_valid, out_data, out_k and locked SHALL all become 0.
REQ-026 Reset SHALL take priority over every in_valid symbol in the same cycle, and that symbol SHALL be dropped.
REQ-027 Reset asserted mid-stream SHALL return the state to UNLOCKED, and the block SHALL need a fresh COM before locked=1.

Structure
REQ-028 The COM and SKP symbol constants, the LFSR seed and the polynomial width SHALL live in shared package pcie_sym_pkg, which the TX scrambler also uses.
REQ-029 The block SHALL instantiate one combinational sub-module, lfsr8_step, that maps the current LFSR to the next LFSR and the 8-bit key, and that sub-module SHALL be reusable by the TX scrambler.

Verification
REQ-030 Stimulus COM, then D 8'hFF, 8'h17, 8'hC0, 8'h14 -> out_data BC, 00, 00, 00, 00, out_k 1,0,0,0,0, and locked=1 from the cycle after the COM output.
REQ-031 Stimulus COM, D 8'hFF, SKP, D 8'h17 -> out_data BC, 00, 1C, 00, which proves that SKP does not advance the LFSR.
REQ-032 Stimulus COM, D 8'hFF, with in_valid low for 3 cycles, then D 8'h17 -> out_data 00 for both D symbols, and out_valid low during the gap.
REQ-033 Stimulus descr_bypass=1, COM, D 8'h5A, 8'hA5 -> out_data BC, 5A, A5, and after dropping bypass the next D symbol uses key 8'hC0.
REQ-034 Stimulus of reset asserted after 2 D symbols, then D 8'h00 without a COM -> locked=0, and out_data = 8'hFF (the seed key).
REQ-035 Stimulus COM, COM, D 8'hFF -> out_data BC, BC, 00.

Source files
------------

// File: rtl/pcie_sym_pkg.sv
// ---------------------------------------------------------------------------
// pcie_sym_pkg
// Constants and types shared by the PCIe Gen1/2 RX descrambler and the TX
// scrambler. It holds the special symbol codes, the LFSR width and seed, the
// lock state encoding, and a helper that derives the per-symbol key from the
// LFSR.
// ---------------------------------------------------------------------------
package pcie_sym_pkg;

    // x^16 + x^5 + x^4 + x^3 + 1 scrambler polynomial width
    localparam int LFSR_W = 16;

    localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 16'hFFFF;
    localparam logic [7:0]        COM_SYM_DEF   = 8'hBC;   // K28.5
    localparam logic [7:0]        SKP_SYM_DEF   = 8'h1C;   // K28.0

    // Lock tracking: leaves UNLOCKED on the first COM and only returns on reset.
    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    // The key comes from the upper LFSR byte in reversed order.
    // key[0] = lfsr[15], ..., key[7] = lfsr[8].
    function automatic logic [7:0] key_from_hi(input logic [7:0] hi);
        logic [7:0] k;
        for (int i = 0; i < 8; i++) begin
            k[i] = hi[7-i];
        end
        return k;
    endfunction

endpackage

// File: rtl/lfsr8_step.sv
// ---------------------------------------------------------------------------
// lfsr8_step
// Purely combinational 8-bit-step advance of the PCIe Gen1/2 scrambler LFSR
// (x^16 + x^5 + x^4 + x^3 + 1). It is shared by the TX scrambler and the RX
// descrambler.
// Ports:
//   i_lfsr      - current LFSR value
//   o_lfsr_next - LFSR value after 8 serial shifts
//   o_key       - key byte for the current symbol (taken from i_lfsr)
// ---------------------------------------------------------------------------
module lfsr8_step
    import pcie_sym_pkg::*;
(
    input  logic [LFSR_W-1:0] i_lfsr,
    output logic [LFSR_W-1:0] o_lfsr_next,
    output logic [7:0]        o_key
);

    logic [LFSR_W-1:0] w_b;

    assign w_b = i_lfsr;

    // Closed form of eight Galois shifts with taps at bits 3, 4 and 5.
    assign o_lfsr_next[0]  = w_b[8];
    assign o_lfsr_next[1]  = w_b[9];
    assign o_lfsr_next[2]  = w_b[10];
    assign o_lfsr_next[3]  = w_b[8]  ^ w_b[11];
    assign o_lfsr_next[4]  = w_b[8]  ^ w_b[9]  ^ w_b[12];
    assign o_lfsr_next[5]  = w_b[8]  ^ w_b[9]  ^ w_b[10] ^ w_b[13];
    assign o_lfsr_next[6]  = w_b[9]  ^ w_b[10] ^ w_b[11] ^ w_b[14];
    assign o_lfsr_next[7]  = w_b[10] ^ w_b[11] ^ w_b[12] ^ w_b[15];
    assign o_lfsr_next[8]  = w_b[0]  ^ w_b[11] ^ w_b[12] ^ w_b[13];
    assign o_lfsr_next[9]  = w_b[1]  ^ w_b[12] ^ w_b[13] ^ w_b[14];
    assign o_lfsr_next[10] = w_b[2]  ^ w_b[13] ^ w_b[14] ^ w_b[15];
    assign o_lfsr_next[11] = w_b[3]  ^ w_b[14] ^ w_b[15];
    assign o_lfsr_next[12] = w_b[4]  ^ w_b[15];
    assign o_lfsr_next[13] = w_b[5];
    assign o_lfsr_next[14] = w_b[6];
    assign o_lfsr_next[15] = w_b[7];

    assign o_key = key_from_hi(w_b[15:8]);

endmodule

// File: rtl/descrambler_8.sv
// ---------------------------------------------------------------------------
// descrambler_8
// PCIe Gen1/2 receive descrambler for one 8-bit symbol per pclk. The output is
// registered with a latency of one cycle. A COM symbol reloads the LFSR seed
// and sets the lock flag. A SKP symbol leaves the LFSR unchanged. Every other
// symbol advances the LFSR. Only D symbols are XORed with the key, and this
// step is skipped while descr_bypass is high.
// Ports:
//   pclk         - clock, rising edge
//   reset        - synchronous active-high reset
//   in_valid     - in_data/in_k carry a symbol this cycle
//   in_data      - decoded symbol
//   in_k         - 1 = K character
//   descr_bypass - 1 = pass D symbols unmodified (the LFSR still runs)
//   out_valid    - out_data/out_k carry a processed symbol
//   out_data     - descrambled symbol
//   out_k        - registered in_k
//   locked       - 1 once a COM has been seen since reset (the FSM state)
//
// Handshake: there is no backpressure. in_valid qualifies a symbol for exactly
// one cycle. out_valid follows it one cycle later. While in_valid is low,
// out_data, out_k and locked hold their values.
// ---------------------------------------------------------------------------
module descrambler_8
    import pcie_sym_pkg::*;
#(
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEF,
    parameter logic [7:0]        COM_SYM   = COM_SYM_DEF,
    parameter logic [7:0]        SKP_SYM   = SKP_SYM_DEF
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_k,
    input  logic       descr_bypass,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_k,
    output logic       locked
);

    logic [LFSR_W-1:0] r_lfsr;
    lock_state_t       r_state;
    logic              r_out_valid;
    logic [7:0]        r_out_data;
    logic              r_out_k;

    logic [LFSR_W-1:0] w_lfsr_next;
    logic [7:0]        w_key;
    logic              w_is_com;
    logic              w_is_skp;

    lfsr8_step u_step (
        .i_lfsr      (r_lfsr),
        .o_lfsr_next (w_lfsr_next),
        .o_key       (w_key)
    );

    assign w_is_com = in_k && (in_data == COM_SYM);
    assign w_is_skp = in_k && (in_data == SKP_SYM);

    always_ff @(posedge pclk) begin
        if (reset) begin
            // A symbol presented during reset is dropped.
            r_lfsr      <= LFSR_SEED;
            r_state     <= ST_UNLOCKED;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_out_k     <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_out_k <= in_k;
                if (w_is_com) begin
                    r_lfsr     <= LFSR_SEED;
                    r_state    <= ST_LOCKED;
                    r_out_data <= in_data;
                end else if (w_is_skp) begin
                    r_out_data <= in_data;
                end else begin
                    // The key comes from the LFSR value before the advance.
                    // Data is XORed even before lock; downstream gates on locked.
                    r_lfsr     <= w_lfsr_next;
                    r_out_data <= (in_k || descr_bypass) ? in_data : (in_data ^ w_key);
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_k     = r_out_k;
    assign locked    = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_descrambler_8.sv
// ---------------------------------------------------------------------------
// tb_descrambler_8
// Directed bench for descrambler_8. The reference keeps the scrambler key
// stream as a table, indexed by how many symbols have advanced since the last
// seed load. A per-cycle checker compares every DUT output against this model.
// Separate literal checks fix the key table and the known output sequences.
// ---------------------------------------------------------------------------
module tb_descrambler_8;

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] SKP = 8'h1C;

    logic       pclk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_k;
    logic       descr_bypass;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_k;
    logic       locked;

    int n_checks = 0;
    int n_errors = 0;

    descrambler_8 dut (
        .pclk         (pclk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_k         (in_k),
        .descr_bypass (descr_bypass),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_k        (out_k),
        .locked       (locked)
    );

    // ---------------- clock ----------------
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // ---------------- key stream table ----------------
    // key_tab[n] is the key for the n-th advancing symbol after a seed load.
    // It is built bit by bit from the serial Galois form of the polynomial.
    logic [7:0] key_tab [256];

    initial begin
        logic [15:0] l;
        logic        fb;
        l = 16'hFFFF;
        for (int n = 0; n < 256; n++) begin
            for (int i = 0; i < 8; i++) begin
                key_tab[n][i] = l[15];
                fb = l[15];
                l = {l[14:0], fb};
                if (fb) l = l ^ 16'h0038;
            end
        end
    end

    // ---------------- reference model ----------------
    // Entry layout: {valid, k, locked, data}
    logic [10:0] exp_q [$];
    int          m_idx;
    logic        m_valid, m_k, m_locked;
    logic [7:0]  m_data;

    always @(posedge pclk) begin
        if (reset) begin
            m_idx = 0; m_locked = 1'b0;
            m_valid = 1'b0; m_k = 1'b0; m_data = 8'h00;
        end else begin
            m_valid = in_valid;
            if (in_valid) begin
                m_k = in_k;
                if (in_k && in_data == COM) begin
                    m_idx = 0; m_locked = 1'b1; m_data = in_data;
                end else if (in_k && in_data == SKP) begin
                    m_data = in_data;
                end else begin
                    m_data = (in_k || descr_bypass) ? in_data : (in_data ^ key_tab[m_idx % 256]);
                    m_idx++;
                end
            end
        end
        exp_q.push_back({m_valid, m_k, m_locked, m_data});
    end

    // ---------------- per-cycle compare + capture ----------------
    logic [7:0] cap_q  [$];
    logic       cap_k  [$];

    always @(negedge pclk) begin
        logic [10:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({out_valid, out_k, locked, out_data} !== e) begin
                n_errors++;
                $display("FAIL cycle_cmp @%0t: valid/k/locked/data got %b/%b/%b/%02h required %b/%b/%b/%02h",
                         $time, out_valid, out_k, locked, out_data, e[10], e[9], e[8], e[7:0]);
            end
            if (out_valid) begin
                cap_q.push_back(out_data);
                cap_k.push_back(out_k);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic k, input logic [7:0] d);
        in_valid = 1'b1; in_k = k; in_data = d;
        @(posedge pclk); #1;
        in_valid = 1'b0; in_k = 1'b0; in_data = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge pclk); #1;
        end
    endtask

    // ---------------- literal sequence checks ----------------
    logic [7:0] exp_seq  [$];
    logic       exp_kseq [$];

    task automatic check_seq(input string name, input bit with_k);
        n_checks++;
        if (cap_q.size() != exp_seq.size()) begin
            n_errors++;
            $display("FAIL %s_len: got %0d symbols required %0d", name, cap_q.size(), exp_seq.size());
        end else begin
            for (int i = 0; i < exp_seq.size(); i++) begin
                n_checks++;
                if (cap_q[i] !== exp_seq[i]) begin
                    n_errors++;
                    $display("FAIL %s_data[%0d]: got %02h required %02h", name, i, cap_q[i], exp_seq[i]);
                end
                if (with_k) begin
                    n_checks++;
                    if (cap_k[i] !== exp_kseq[i]) begin
                        n_errors++;
                        $display("FAIL %s_k[%0d]: got %b required %b", name, i, cap_k[i], exp_kseq[i]);
                    end
                end
            end
        end
        cap_q.delete();
        cap_k.delete();
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s: got %b required %b", name, got, req);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] first_keys [4];
        first_keys[0] = 8'hFF; first_keys[1] = 8'h17;
        first_keys[2] = 8'hC0; first_keys[3] = 8'h14;

        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_k = 1'b0; descr_bypass = 1'b0;
        idle(3);
        check_bit("reset_out_valid", out_valid, 1'b0);
        check_bit("reset_locked", locked, 1'b0);
        reset = 1'b0;
        idle(1);

        // Fix the start of the key table at the known PCIe key stream.
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (key_tab[i] !== first_keys[i]) begin
                n_errors++;
                $display("FAIL key_tab[%0d]: got %02h required %02h", i, key_tab[i], first_keys[i]);
            end
        end

        // COM followed by the raw key stream descrambles to zeros.
        cap_q.delete(); cap_k.delete();
        send(1'b1, COM); send(1'b0, 8'hFF); send(1'b0, 8'h17); send(1'b0, 8'hC0); send(1'b0, 8'h14);
        idle(2);
        exp_seq  = '{8'hBC, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_kseq = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        check_seq("com_stream", 1'b1);
        check_bit("locked_after_com", locked, 1'b1);

        // A SKP does not advance the LFSR.
        send(1'b1, COM); send(1'b0, 8'hFF); send(1'b1, SKP); send(1'b0, 8'h17);
        idle(2);
        exp_seq = '{8'hBC, 8'h00, 8'h1C, 8'h00};
        check_seq("skp_hold", 1'b0);

        // Idle cycles hold the LFSR.
        send(1'b1, COM); send(1'b0, 8'hFF); idle(3); send(1'b0, 8'h17);
        idle(2);
        exp_seq = '{8'hBC, 8'h00, 8'h00};
        check_seq("valid_gap", 1'b0);

        // In bypass the data passes through and the LFSR still advances.
        descr_bypass = 1'b1;
        send(1'b1, COM); send(1'b0, 8'h5A); send(1'b0, 8'hA5);
        descr_bypass = 1'b0;
        send(1'b0, 8'hC0);
        idle(2);
        exp_seq = '{8'hBC, 8'h5A, 8'hA5, 8'h00};
        check_seq("bypass", 1'b0);

        // Longer mixed stream, checked by the model on every cycle.
        send(1'b1, COM);
        for (int i = 0; i < 20; i++) begin
            if (i == 7)       send(1'b1, 8'hFC);   // other K: advances, passes
            else if (i == 11) send(1'b1, SKP);
            else begin
                if (i == 14) idle(2);
                send(1'b0, 8'((i * 37 + 3) & 8'hFF));
            end
        end
        idle(2);
        cap_q.delete(); cap_k.delete();

        // Reset mid-stream: the symbol presented during reset is dropped, and the
        // block must come up unlocked using the seed key.
        send(1'b1, COM); send(1'b0, 8'hFF); send(1'b0, 8'h17);
        reset = 1'b1; in_valid = 1'b1; in_k = 1'b0; in_data = 8'h55;
        @(posedge pclk); #1;
        reset = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        check_bit("reset_mid_locked", locked, 1'b0);
        check_bit("reset_mid_drop", out_valid, 1'b0);
        send(1'b0, 8'h00);
        idle(2);
        exp_seq = '{8'hBC, 8'h00, 8'h00, 8'hFF};
        check_seq("reset_mid", 1'b0);
        check_bit("locked_after_reset_d", locked, 1'b0);

        // Each of two back-to-back COMs reloads the seed.
        send(1'b1, COM); send(1'b0, 8'h33); send(1'b1, COM); send(1'b1, COM); send(1'b0, 8'hFF);
        idle(2);
        exp_seq = '{8'hBC, 8'h33 ^ 8'hFF, 8'hBC, 8'hBC, 8'h00};
        check_seq("com_com", 1'b0);
        check_bit("locked_final", locked, 1'b1);

        idle(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
